// File: rtl/count_stream_checker_if.sv
// Sample/flag bundle between a counter-stream source and its checker.
// The source side drives samples and resync; the checker returns lock status and error flags.
interface count_stream_checker_if #(
    parameter int ERR_W = 16
);
    logic             resync;
    logic             sample_valid;
    logic [7:0]       sample_in;
    logic             locked;
    logic             mismatch;
    logic [7:0]       expected;
    logic [ERR_W-1:0] error_count;

    modport master (
        output resync, sample_valid, sample_in,
        input  locked, mismatch, expected, error_count
    );

    modport slave (
        input  resync, sample_valid, sample_in,
        output locked, mismatch, expected, error_count
    );
endinterface

// File: rtl/count_stream_checker.sv
// Receive-side checker for the {hi,lo} cascaded-counter stream: hunts, verifies, locks,
// then flywheels on its own prediction while counting misses and saturating errors.
module count_stream_checker #(
    parameter int CARRY_AT   = 7,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_LIMIT = 2,
    parameter int ERR_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_clear,
    count_stream_checker_if.slave bus
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_exp, w_exp_nxt;
    logic [3:0]       r_match, w_match_nxt;
    logic [3:0]       r_miss, w_miss_nxt;
    logic [ERR_W-1:0] r_err, w_err_nxt;
    logic             r_mm, w_mm_nxt;
    logic             r_locked;

    logic             w_hit;
    logic [4:0]       w_match_inc;
    logic [4:0]       w_miss_inc;

    // Carry is judged on the lo nibble before it increments.
    function automatic logic [7:0] f_next(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4] + {3'b000, (v[3:0] == 4'(CARRY_AT))};
        lo = v[3:0] + 4'd1;
        return {hi, lo};
    endfunction

    assign w_hit       = (bus.sample_in == r_exp);
    assign w_match_inc = {1'b0, r_match} + 5'd1;
    assign w_miss_inc  = {1'b0, r_miss} + 5'd1;

    always_ff @(posedge i_clk or posedge i_clear) begin
        if (i_clear) begin
            r_state  <= ST_HUNT;
            r_exp    <= 8'h00;
            r_match  <= 4'd0;
            r_miss   <= 4'd0;
            r_err    <= '0;
            r_mm     <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_exp    <= w_exp_nxt;
            r_match  <= w_match_nxt;
            r_miss   <= w_miss_nxt;
            r_err    <= w_err_nxt;
            r_mm     <= w_mm_nxt;
            r_locked <= (w_state_nxt == ST_LOCKED);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_match_nxt = r_match;
        w_miss_nxt  = r_miss;
        w_err_nxt   = r_err;
        w_mm_nxt    = 1'b0;

        if (bus.resync) begin
            w_state_nxt = ST_HUNT;
            w_exp_nxt   = 8'h00;
            w_match_nxt = 4'd0;
            w_miss_nxt  = 4'd0;
        end else if (bus.sample_valid) begin
            case (r_state)
                ST_HUNT: begin
                    w_exp_nxt   = f_next(bus.sample_in);
                    w_match_nxt = 4'd0;
                    w_state_nxt = ST_VERIFY;
                end
                ST_VERIFY: begin
                    // Either way we realign to the received sample; only the run length differs.
                    w_exp_nxt = f_next(bus.sample_in);
                    if (w_hit) begin
                        if (w_match_inc == 5'(LOCK_COUNT)) begin
                            w_state_nxt = ST_LOCKED;
                            w_match_nxt = 4'd0;
                            w_miss_nxt  = 4'd0;
                        end else begin
                            w_match_nxt = w_match_inc[3:0];
                        end
                    end else begin
                        w_match_nxt = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    w_exp_nxt = f_next(r_exp);
                    if (w_hit) begin
                        w_miss_nxt = 4'd0;
                    end else begin
                        w_mm_nxt = 1'b1;
                        if (r_err != {ERR_W{1'b1}})
                            w_err_nxt = r_err + ERR_W'(1);
                        if (w_miss_inc == 5'(LOSS_LIMIT)) begin
                            w_state_nxt = ST_HUNT;
                            w_exp_nxt   = 8'h00;
                            w_match_nxt = 4'd0;
                            w_miss_nxt  = 4'd0;
                        end else begin
                            w_miss_nxt = w_miss_inc[3:0];
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_exp_nxt   = 8'h00;
                    w_match_nxt = 4'd0;
                    w_miss_nxt  = 4'd0;
                end
            endcase
        end
    end

    assign bus.locked      = r_locked;
    assign bus.mismatch    = r_mm;
    assign bus.expected    = r_exp;
    assign bus.error_count = r_err;

endmodule

// File: tb/tb_count_stream_checker.sv
// Randomized and directed bench for count_stream_checker against a behavioural stream model.
module tb_count_stream_checker;

    logic clk;
    logic clear;
    int   n_pass;
    int   n_total;

    // Model state: 0 = hunting, 1 = verifying, 2 = locked
    int         m_mode;
    logic [7:0] m_exp;
    int         m_run;
    int         m_misses;
    int         m_err;
    logic       m_mm;

    count_stream_checker_if #(.ERR_W(16)) bus ();
    count_stream_checker_if #(.ERR_W(4))  bus_s ();

    count_stream_checker #(
        .CARRY_AT(7), .LOCK_COUNT(4), .LOSS_LIMIT(2), .ERR_W(16)
    ) u_dut (
        .i_clk(clk), .i_clear(clear), .bus(bus.slave)
    );

    count_stream_checker #(
        .CARRY_AT(7), .LOCK_COUNT(4), .LOSS_LIMIT(15), .ERR_W(4)
    ) u_dut_sat (
        .i_clk(clk), .i_clear(clear), .bus(bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_next(input logic [7:0] v);
        int hi;
        int lo;
        hi = int'(v) / 16;
        lo = int'(v) % 16;
        if (lo == 7) hi = (hi + 1) % 16;
        lo = (lo + 1) % 16;
        return 8'(hi * 16 + lo);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_exp = 8'h00; m_run = 0; m_misses = 0; m_err = 0; m_mm = 1'b0;
    endtask

    task automatic model_apply(input logic v, input logic [7:0] s, input logic r);
        m_mm = 1'b0;
        if (r) begin
            m_mode = 0; m_exp = 8'h00; m_run = 0; m_misses = 0;
        end else if (v) begin
            if (m_mode == 0) begin
                m_exp = ref_next(s); m_run = 0; m_mode = 1;
            end else if (m_mode == 1) begin
                if (s == m_exp) begin
                    m_run++;
                    if (m_run == 4) begin m_mode = 2; m_misses = 0; end
                end else begin
                    m_run = 0;
                end
                m_exp = ref_next(s);
            end else begin
                if (s == m_exp) begin
                    m_misses = 0;
                    m_exp = ref_next(m_exp);
                end else begin
                    m_mm = 1'b1;
                    if (m_err < 65535) m_err++;
                    m_misses++;
                    m_exp = ref_next(m_exp);
                    if (m_misses == 2) begin
                        m_mode = 0; m_exp = 8'h00; m_run = 0; m_misses = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] s, input logic r);
        @(negedge clk);
        bus.sample_valid = v;
        bus.sample_in    = s;
        bus.resync       = r;
        @(posedge clk);
        #1;
        model_apply(v, s, r);
        bus.sample_valid = 1'b0;
        bus.resync       = 1'b0;
    endtask

    task automatic step_s(input logic v, input logic [7:0] s);
        @(negedge clk);
        bus_s.sample_valid = v;
        bus_s.sample_in    = s;
        @(posedge clk);
        #1;
        bus_s.sample_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    task automatic lock_on(input logic [7:0] start);
        logic [7:0] s;
        s = start;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, s, 1'b0);
            s = ref_next(s);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear = 1'b1;
        #1;
        n_total++;
        if ({bus.locked, bus.mismatch, bus.expected, bus.error_count} !== 26'd0)
            $display("FAIL reset_outputs: got lk=%0b mm=%0b exp=%02h err=%0d, need all 0",
                     bus.locked, bus.mismatch, bus.expected, bus.error_count);
        else n_pass++;
        n_total++;
        if ({bus_s.locked, bus_s.mismatch, bus_s.expected, bus_s.error_count} !== 14'd0)
            $display("FAIL reset_outputs_sat: got lk=%0b exp=%02h err=%0d, need all 0",
                     bus_s.locked, bus_s.expected, bus_s.error_count);
        else n_pass++;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    task automatic test_lock_acquire();
        do_clear();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(i), 1'b0);
            n_total++;
            if (bus.locked !== (i == 4) || bus.mismatch !== 1'b0)
                $display("FAIL lock_seq[%0d]: got lk=%0b mm=%0b, need lk=%0b mm=0",
                         i, bus.locked, bus.mismatch, (i == 4));
            else n_pass++;
        end
        n_total++;
        if (bus.expected !== 8'h05 || bus.error_count !== 16'd0)
            $display("FAIL lock_expected: got exp=%02h err=%0d, need exp=05 err=0",
                     bus.expected, bus.error_count);
        else n_pass++;
    endtask

    task automatic test_carry_gaps();
        logic [7:0] seq [5];
        seq = '{8'h05, 8'h06, 8'h07, 8'h18, 8'h19};
        foreach (seq[i]) begin
            step(1'b1, seq[i], 1'b0);
            n_total++;
            if (bus.mismatch !== 1'b0 || bus.locked !== 1'b1)
                $display("FAIL carry_seq[%0d]: got mm=%0b lk=%0b, need mm=0 lk=1",
                         i, bus.mismatch, bus.locked);
            else n_pass++;
            step(1'b0, 8'hAA, 1'b0);
            step(1'b0, 8'h55, 1'b0);
        end
        n_total++;
        if (bus.expected !== 8'h1A)
            $display("FAIL carry_expected: got %02h, need 1A", bus.expected);
        else n_pass++;
        step(1'b1, 8'h1B, 1'b0);
        n_total++;
        if (bus.mismatch !== 1'b1 || bus.error_count !== 16'd1 ||
            bus.expected !== 8'h1B || bus.locked !== 1'b1)
            $display("FAIL single_miss: got mm=%0b err=%0d exp=%02h lk=%0b, need 1/1/1B/1",
                     bus.mismatch, bus.error_count, bus.expected, bus.locked);
        else n_pass++;
        step(1'b0, 8'h00, 1'b0);
        n_total++;
        if (bus.mismatch !== 1'b0)
            $display("FAIL miss_pulse_width: got mm=%0b, need 0", bus.mismatch);
        else n_pass++;
    endtask

    task automatic test_loss_of_lock();
        do_clear();
        lock_on(8'h3B);
        n_total++;
        if (bus.locked !== 1'b1 || bus.expected !== 8'h30)
            $display("FAIL loss_setup: got lk=%0b exp=%02h, need lk=1 exp=30",
                     bus.locked, bus.expected);
        else n_pass++;
        step(1'b1, 8'h55, 1'b0);
        n_total++;
        if (bus.mismatch !== 1'b1 || bus.locked !== 1'b1 || bus.error_count !== 16'd1)
            $display("FAIL loss_first: got mm=%0b lk=%0b err=%0d, need 1/1/1",
                     bus.mismatch, bus.locked, bus.error_count);
        else n_pass++;
        step(1'b1, 8'h55, 1'b0);
        n_total++;
        if (bus.mismatch !== 1'b1 || bus.locked !== 1'b0 ||
            bus.error_count !== 16'd2 || bus.expected !== 8'h00)
            $display("FAIL loss_second: got mm=%0b lk=%0b err=%0d exp=%02h, need 1/0/2/00",
                     bus.mismatch, bus.locked, bus.error_count, bus.expected);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] seq [10];
        do_clear();
        lock_on(8'hF2);
        seq = '{8'hF7, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h00};
        foreach (seq[i]) begin
            step(1'b1, seq[i], 1'b0);
            n_total++;
            if (bus.mismatch !== 1'b0 || bus.locked !== 1'b1)
                $display("FAIL wrap_seq[%0d]: sample %02h got mm=%0b lk=%0b, need 0/1",
                         i, seq[i], bus.mismatch, bus.locked);
            else n_pass++;
        end
        n_total++;
        if (bus.expected !== 8'h01 || bus.error_count !== 16'd0)
            $display("FAIL wrap_end: got exp=%02h err=%0d, need 01/0",
                     bus.expected, bus.error_count);
        else n_pass++;
    endtask

    task automatic test_resync();
        logic [15:0] err_before;
        err_before = bus.error_count;
        step(1'b1, ~bus.expected, 1'b1);
        n_total++;
        if (bus.locked !== 1'b0 || bus.mismatch !== 1'b0 ||
            bus.expected !== 8'h00 || bus.error_count !== err_before)
            $display("FAIL resync: got lk=%0b mm=%0b exp=%02h err=%0d, need 0/0/00/%0d",
                     bus.locked, bus.mismatch, bus.expected, bus.error_count, err_before);
        else n_pass++;
    endtask

    task automatic test_async_clear();
        do_clear();
        lock_on(8'h40);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, m_exp ^ 8'h80, 1'b0);
            step(1'b1, m_exp, 1'b0);
        end
        n_total++;
        if (bus.error_count !== 16'd3 || bus.locked !== 1'b1)
            $display("FAIL clear_setup: got err=%0d lk=%0b, need 3/1",
                     bus.error_count, bus.locked);
        else n_pass++;
        #3;
        clear = 1'b1;
        #1;
        n_total++;
        if ({bus.locked, bus.mismatch, bus.expected, bus.error_count} !== 26'd0)
            $display("FAIL async_clear: got lk=%0b mm=%0b exp=%02h err=%0d, need all 0",
                     bus.locked, bus.mismatch, bus.expected, bus.error_count);
        else n_pass++;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic       v;
        logic       r;
        logic [7:0] s;
        do_clear();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 9) < 8) ? m_exp : 8'($urandom_range(0, 255));
            step(v, s, r);
            n_total++;
            if (bus.locked !== (m_mode == 2) || bus.mismatch !== m_mm ||
                bus.expected !== m_exp || bus.error_count !== 16'(m_err))
                $display("FAIL random[%0d]: got lk=%0b mm=%0b exp=%02h err=%0d, need lk=%0b mm=%0b exp=%02h err=%0d",
                         i, bus.locked, bus.mismatch, bus.expected, bus.error_count,
                         (m_mode == 2), m_mm, m_exp, m_err);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [7:0] e;
        do_clear();
        e = 8'h10;
        for (int i = 0; i < 5; i++) begin
            step_s(1'b1, e);
            e = ref_next(e);
        end
        for (int k = 1; k <= 20; k++) begin
            step_s(1'b1, e ^ 8'h80);
            e = ref_next(e);
            n_total++;
            if (bus_s.mismatch !== 1'b1 || bus_s.error_count !== 4'((k > 15) ? 15 : k))
                $display("FAIL sat_miss[%0d]: got mm=%0b err=%0d, need mm=1 err=%0d",
                         k, bus_s.mismatch, bus_s.error_count, (k > 15) ? 15 : k);
            else n_pass++;
            step_s(1'b1, e);
            e = ref_next(e);
        end
        n_total++;
        if (bus_s.error_count !== 4'd15 || bus_s.locked !== 1'b1)
            $display("FAIL sat_end: got err=%0d lk=%0b, need 15/1",
                     bus_s.error_count, bus_s.locked);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        clear = 1'b1;
        bus.resync = 1'b0; bus.sample_valid = 1'b0; bus.sample_in = 8'h00;
        bus_s.resync = 1'b0; bus_s.sample_valid = 1'b0; bus_s.sample_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_lock_acquire();
        test_carry_gaps();
        test_loss_of_lock();
        test_wrap();
        test_resync();
        test_async_clear();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/count_stream_checker.md
Name: count_stream_checker

Overview:
- Receive-side monitor for the 8-bit cascaded-counter stream {hi_nibble, lo_nibble} produced by the team's two-counter generator.
- Locks onto the incoming sequence, predicts each next value, and flags mismatches.
- Keeps a saturating error count and drops lock after repeated misses.
- Sits at the far end of the counter link as its self-checking consumer.

Parameters:
- CARRY_AT, 7: lo-nibble value on which the hi nibble advances (4-bit, 0..15).
- LOCK_COUNT, 4: consecutive matches in VERIFY required to declare lock (1..15).
- LOSS_LIMIT, 2: consecutive mismatches in LOCKED that drop lock (1..15).
- ERR_W, 16: width of error_count.

Ports:
- clk, input, 1: single clock, rising edge.
- clear, input, 1: asynchronous active-high reset.
- resync, input, 1: synchronous request to return to HUNT; error_count is kept.
- sample_valid, input, 1: sample_in is consumed on this edge.
- sample_in, input, 8: received counter value {hi[7:4], lo[3:0]}.
- locked, output, 1: high while in LOCKED.
- mismatch, output, 1: one-cycle pulse; a consumed sample mismatched while LOCKED.
- expected, output, 8: predicted next sample; 0 in HUNT.
- error_count, output, ERR_W: saturating count of LOCKED mismatches.

Behaviour:
- Prediction: next(v) = {v[7:4] + (v[3:0]==CARRY_AT), v[3:0] + 1}.
  - Each nibble wraps modulo 16 independently.
  - The carry test uses the pre-increment lo nibble, e.g. next(0x07) = 0x18, next(0x0F) = 0x00, next(0xF7) = 0x08.
- Reset (clear=1, asynchronous):
  - State goes to HUNT.
  - locked=0, mismatch=0, expected=0, error_count=0.
  - Internal match and miss counters = 0.
- All outputs are registered. Each output updates on the same edge that consumes the sample, giving 1-cycle latency from sample to flag.
- Cycles with sample_valid=0 change nothing except that mismatch returns to 0. Gaps between samples are allowed and do not count as misses.
- Priority: clear > resync > sample processing.
  - resync: state to HUNT; expected, match and miss counters to 0; mismatch=0.
  - A sample presented in the resync cycle is ignored.
- HUNT:
  - On a valid sample: expected <= next(sample_in), match_cnt <= 0, go to VERIFY.
  - No mismatch pulse.
- VERIFY:
  - Match (sample_in == expected): expected <= next(sample_in), match_cnt++.
  - When match_cnt reaches LOCK_COUNT, go to LOCKED (locked=1) on that edge and clear miss_cnt.
  - Mismatch: realign, i.e. expected <= next(sample_in), match_cnt <= 0, stay in VERIFY.
  - No mismatch pulse and no error_count change in VERIFY.
- LOCKED:
  - Match: expected <= next(expected), miss_cnt <= 0.
  - Mismatch:
    - mismatch=1 for one cycle.
    - error_count++, saturating at all-ones and holding there.
    - expected <= next(expected); the checker flywheels and does not realign.
    - miss_cnt++.
    - When miss_cnt reaches LOSS_LIMIT: go to HUNT, locked=0, expected=0, counters cleared. mismatch still pulses for this final sample.
- Simultaneous events:
  - A mismatch on the same edge as resync is not counted.
  - clear mid-stream aborts immediately regardless of state.

Test Plan:
- Lock acquisition: after clear, feed 0x00, 0x01, 0x02, 0x03, 0x04 on consecutive cycles.
  - locked rises on the edge consuming 0x04.
  - expected = 0x05; mismatch never asserted; error_count = 0.
- Carry and gaps: while locked, feed 0x06, 0x07, 0x18, 0x19 with idle cycles between samples.
  - No mismatch; expected = 0x1A.
  - Then feed 0x1B instead of 0x1A: mismatch pulses once, error_count = 1, expected = 0x1B, still locked.
- Loss of lock (LOSS_LIMIT=2): while locked expecting 0x30, feed 0x55 then 0x55.
  - mismatch pulses on both samples; error_count = 2.
  - locked falls on the second; state HUNT; expected = 0.
- Wrap boundaries: lock on the sequence ending 0xF5, 0xF6; then feed 0xF7, 0x08, 0x09, ..., 0x0F, 0x00.
  - Zero mismatches: hi wraps F to 0 at the carry, lo wraps F to 0 with no carry.
- Reset and resync:
  - Assert clear asynchronously mid-cycle while locked with error_count = 3: all outputs go to 0 before the next edge.
  - Separately, pulse resync while locked with a mismatching sample present: locked = 0, error_count unchanged, no mismatch pulse.
- Saturation (ERR_W=4, LOSS_LIMIT=15): force 20 isolated mismatches, each followed by a match, while locked.
  - error_count stops at 15; locked stays 1.
